// File: rtl/mac_pkg.sv
// mac_pkg: shared MAC transmit widths and the arbiter state encoding
package mac_pkg;
    localparam int MAC_WORD_WIDTH        = 32;
    localparam int MAC_FRAME_COUNT_WIDTH = 7;
    localparam int MAC_MAX_FRAME_WORDS   = 380;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_PASS,
        ARB_DRAIN
    } arb_state_e;
endpackage

// File: rtl/mac_rr_pick.sv
// mac_rr_pick: combinational round-robin picker, first request at/after ptr wins
module mac_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_PORTS-1:0] pick,
    output logic                 valid
);
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!valid && i >= int'(ptr) && req[i]) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
        // wrap-around pass covers the ports below the pointer
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!valid && i < int'(ptr) && req[i]) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-level round-robin arbiter feeding the MAC transmit input
import mac_pkg::*;

module mac_tx_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WIDTH  = MAC_WORD_WIDTH,
    parameter int FRAME_LIMIT = 60,
    parameter int MAX_WORDS   = MAC_MAX_FRAME_WORDS
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_start,
    input  logic [NUM_PORTS-1:0]              req_end,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [MAC_FRAME_COUNT_WIDTH-1:0]  frame_count,
    output logic [DATA_WIDTH-1:0]             data_in,
    output logic                              data_in_enable,
    output logic                              data_in_start,
    output logic                              data_in_end,
    output logic [NUM_PORTS-1:0]              grant,
    output logic                              busy,
    output logic                              truncated,
    output logic                              protocol_error
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_WORDS + 1);

    arb_state_e            state, state_n;
    logic [NUM_PORTS-1:0]  grant_n, pick;
    logic [PW-1:0]         ptr, ptr_n, own_next;
    logic [CW-1:0]         count, count_n;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  own_valid, own_start, own_end, pick_valid, accept, last_word;
    logic                  out_en_n, out_start_n, out_end_n, trunc_n, perr_n;

    mac_rr_pick #(.NUM_PORTS(NUM_PORTS), .PTR_WIDTH(PW)) u_pick (
        .req   (req_valid & req_start),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        own_data  = '0;
        own_valid = 1'b0;
        own_start = 1'b0;
        own_end   = 1'b0;
        own_next  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_valid = req_valid[i];
                own_start = req_start[i];
                own_end   = req_end[i];
                own_next  = (i == NUM_PORTS - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // idle flushes stray mid-frame words; otherwise only the owner is served
    assign req_ready = (state == ARB_IDLE) ? (req_valid & ~req_start) : grant;
    assign accept    = (state != ARB_IDLE) && own_valid;
    assign last_word = count == CW'(MAX_WORDS - 1);
    assign busy      = state != ARB_IDLE;

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        ptr_n       = ptr;
        count_n     = count;
        out_en_n    = 1'b0;
        out_start_n = 1'b0;
        out_end_n   = 1'b0;
        trunc_n     = 1'b0;
        perr_n      = 1'b0;
        if (state == ARB_IDLE) begin
            if (pick_valid && int'(frame_count) < FRAME_LIMIT) begin
                grant_n = pick;
                state_n = ARB_PASS;
            end
        end else if (accept) begin
            if (own_end) begin
                state_n = ARB_IDLE;
                grant_n = '0;
                ptr_n   = own_next;
                count_n = '0;
            end
            if (state == ARB_PASS) begin
                out_en_n    = 1'b1;
                out_start_n = count == '0;
                out_end_n   = own_end || last_word;
                perr_n      = own_start && count != '0;
                count_n     = own_end ? '0 : count + CW'(1);
                if (!own_end && last_word) begin
                    trunc_n = 1'b1;
                    state_n = ARB_DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ARB_IDLE;
            grant          <= '0;
            ptr            <= '0;
            count          <= '0;
            data_in        <= '0;
            data_in_enable <= 1'b0;
            data_in_start  <= 1'b0;
            data_in_end    <= 1'b0;
            truncated      <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state          <= state_n;
            grant          <= grant_n;
            ptr            <= ptr_n;
            count          <= count_n;
            data_in_enable <= out_en_n;
            data_in_start  <= out_start_n;
            data_in_end    <= out_end_n;
            truncated      <= trunc_n;
            protocol_error <= perr_n;
            if (out_en_n) data_in <= own_data;
        end
    end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: table-driven and directed checks of the frame arbiter
module tb_mac_tx_arbiter;
    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] req_data;
    logic [3:0]   req_valid, req_start, req_end, req_ready, grant;
    logic [6:0]   frame_count;
    logic [31:0]  data_in;
    logic         data_in_enable, data_in_start, data_in_end, busy, truncated, protocol_error;
    logic [27:0]  word;
    int           total = 0;
    int           bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  v, s, e;
        logic [27:0] w;
        logic [6:0]  fc;
        logic [3:0]  rdy, gnt;
        logic        en, st, nd;
        logic [31:0] d;
        logic        tr, pe;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    // each port tags its word with its own index in the top nibble
    always_comb
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = {4'(i), word};

    mac_tx_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_start      (req_start),
        .req_end        (req_end),
        .req_ready      (req_ready),
        .frame_count    (frame_count),
        .data_in        (data_in),
        .data_in_enable (data_in_enable),
        .data_in_start  (data_in_start),
        .data_in_end    (data_in_end),
        .grant          (grant),
        .busy           (busy),
        .truncated      (truncated),
        .protocol_error (protocol_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] v, s, e, input logic [27:0] w,
                       input logic [6:0] fc, input logic [3:0] rdy, gnt,
                       input logic en, st, nd, input logic [31:0] d, input logic tr, pe);
        vec_t r;
        r.rst = rst; r.v = v; r.s = s; r.e = e; r.w = w; r.fc = fc;
        r.rdy = rdy; r.gnt = gnt; r.en = en; r.st = st; r.nd = nd; r.d = d; r.tr = tr; r.pe = pe;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic [3:0] v, s, e, input logic [27:0] w);
        req_valid = v;
        req_start = s;
        req_end   = e;
        word      = w;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic en, st, nd, input logic [31:0] d,
                              input logic [3:0] gnt, input logic tr, pe);
        chk({tag, " enable"}, 32'(data_in_enable), 32'(en));
        chk({tag, " start"}, 32'(data_in_start), 32'(st));
        chk({tag, " end"}, 32'(data_in_end), 32'(nd));
        if (en) chk({tag, " data"}, data_in, d);
        chk({tag, " grant"}, 32'(grant), 32'(gnt));
        chk({tag, " busy"}, 32'(busy), 32'(gnt != 4'b0));
        chk({tag, " truncated"}, 32'(truncated), 32'(tr));
        chk({tag, " protocol_error"}, 32'(protocol_error), 32'(pe));
    endtask

    initial begin
        reset = 1'b1;
        frame_count = '0;
        drive(0, 0, 0, 0);
        // rst  v  s  e  w       fc  rdy gnt en st nd data           tr pe
        add(1, 0, 0, 0, 0,      0,  0,  0,  0, 0, 0, 0,             0, 0);
        add(0, 1, 1, 0, 'hA0,   0,  0,  1,  0, 0, 0, 0,             0, 0);
        add(0, 1, 1, 0, 'hA0,   0,  1,  1,  1, 1, 0, 32'h0000_00A0, 0, 0);
        add(0, 1, 0, 0, 'hA1,   0,  1,  1,  1, 0, 0, 32'h0000_00A1, 0, 0);
        add(0, 1, 0, 1, 'hA2,   0,  1,  0,  1, 0, 1, 32'h0000_00A2, 0, 0);
        add(0, 0, 0, 0, 0,      0,  0,  0,  0, 0, 0, 0,             0, 0);
        add(1, 0, 0, 0, 0,      0,  0,  0,  0, 0, 0, 0,             0, 0);
        add(0, 7, 7, 0, 'hB0,   0,  0,  1,  0, 0, 0, 0,             0, 0);
        add(0, 7, 7, 0, 'hB0,   0,  1,  1,  1, 1, 0, 32'h0000_00B0, 0, 0);
        add(0, 7, 6, 1, 'hB1,   0,  1,  0,  1, 0, 1, 32'h0000_00B1, 0, 0);
        add(0, 6, 6, 0, 'hC0,   0,  0,  2,  0, 0, 0, 0,             0, 0);
        add(0, 6, 6, 0, 'hC0,   0,  2,  2,  1, 1, 0, 32'h1000_00C0, 0, 0);
        add(0, 6, 4, 2, 'hC1,   0,  2,  0,  1, 0, 1, 32'h1000_00C1, 0, 0);
        add(0, 5, 5, 0, 'hD0,   0,  0,  4,  0, 0, 0, 0,             0, 0);
        add(0, 5, 5, 0, 'hD0,   0,  4,  4,  1, 1, 0, 32'h2000_00D0, 0, 0);
        add(0, 5, 1, 4, 'hD1,   0,  4,  0,  1, 0, 1, 32'h2000_00D1, 0, 0);
        add(0, 1, 1, 0, 'hE0,   0,  0,  1,  0, 0, 0, 0,             0, 0);
        add(0, 1, 1, 0, 'hE0,   0,  1,  1,  1, 1, 0, 32'h0000_00E0, 0, 0);
        add(0, 1, 0, 1, 'hE1,   0,  1,  0,  1, 0, 1, 32'h0000_00E1, 0, 0);
        add(0, 2, 2, 0, 'hF0,   60, 0,  0,  0, 0, 0, 0,             0, 0);
        add(0, 2, 2, 0, 'hF0,   60, 0,  0,  0, 0, 0, 0,             0, 0);
        add(0, 2, 2, 0, 'hF0,   59, 0,  2,  0, 0, 0, 0,             0, 0);
        add(0, 2, 2, 2, 'hF0,   60, 2,  0,  1, 1, 1, 32'h1000_00F0, 0, 0);
        add(0, 0, 0, 0, 0,      0,  0,  0,  0, 0, 0, 0,             0, 0);
        add(0, 8, 0, 0, 'h77,   0,  8,  0,  0, 0, 0, 0,             0, 0);
        add(0, 0, 0, 0, 0,      0,  0,  0,  0, 0, 0, 0,             0, 0);
        repeat (2) cyc();
        foreach (tbl[k]) begin
            reset       = tbl[k].rst;
            frame_count = tbl[k].fc;
            drive(tbl[k].v, tbl[k].s, tbl[k].e, tbl[k].w);
            #1;
            chk($sformatf("row%0d ready", k), 32'(req_ready), 32'(tbl[k].rdy));
            cyc();
            expect_out($sformatf("row%0d", k), tbl[k].en, tbl[k].st, tbl[k].nd, tbl[k].d,
                       tbl[k].gnt, tbl[k].tr, tbl[k].pe);
        end

        // runaway frame on port 3: cut at word 380, remainder drained silently
        drive(8, 8, 0, 0);
        cyc();
        expect_out("trunc grant", 0, 0, 0, 0, 8, 0, 0);
        for (int k = 0; k < 400; k++) begin
            drive(8, (k == 0) ? 4'd8 : 4'd0, (k == 399) ? 4'd8 : 4'd0, 28'(k));
            #1;
            chk($sformatf("trunc ready %0d", k), 32'(req_ready), 32'h8);
            cyc();
            expect_out($sformatf("trunc w%0d", k), k < 380, k == 0, k == 379, {4'd3, 28'(k)},
                       (k == 399) ? 4'd0 : 4'd8, k == 379, 0);
        end
        drive(1, 1, 1, 'h55);
        cyc();
        expect_out("post-trunc grant", 0, 0, 0, 0, 1, 0, 0);
        cyc();
        expect_out("post-trunc frame", 1, 1, 1, 32'h0000_0055, 0, 0, 0);

        // stray start inside a port 2 frame
        drive(4, 4, 0, 'h20);
        cyc();
        expect_out("perr grant", 0, 0, 0, 0, 4, 0, 0);
        cyc();
        expect_out("perr w0", 1, 1, 0, 32'h2000_0020, 4, 0, 0);
        drive(4, 0, 0, 'h21);
        cyc();
        expect_out("perr w1", 1, 0, 0, 32'h2000_0021, 4, 0, 0);
        drive(4, 4, 0, 'h22);
        cyc();
        expect_out("perr w2", 1, 0, 0, 32'h2000_0022, 4, 0, 1);
        drive(4, 0, 4, 'h23);
        cyc();
        expect_out("perr w3", 1, 0, 1, 32'h2000_0023, 0, 0, 0);

        // reset in the middle of a port 1 frame
        drive(2, 2, 0, 'h30);
        cyc();
        expect_out("rst grant", 0, 0, 0, 0, 2, 0, 0);
        cyc();
        expect_out("rst w0", 1, 1, 0, 32'h1000_0030, 2, 0, 0);
        drive(2, 0, 0, 'h31);
        reset = 1'b1;
        cyc();
        expect_out("rst mid", 0, 0, 0, 0, 0, 0, 0);
        chk("rst data_in", data_in, 32'h0);
        reset = 1'b0;
        drive(3, 3, 3, 'h40);
        cyc();
        expect_out("rst regrant", 0, 0, 0, 0, 1, 0, 0);
        cyc();
        expect_out("rst frame", 1, 1, 1, 32'h0000_0040, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
